// File: rtl/addkey_round.sv
// AddRoundKey stage with round sequencing for an iterative AES datapath.
// Each ok_col pulse XORs the column-mix result with the current round key.
// Intermediate rounds are fed back on plain_key/ok_key. The last round
// (round_num == NR) lands in cipher/done and ends the block.
module addkey_round #(
  parameter int unsigned NR = 10  // cipher rounds: 10, 12 or 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [128:1]   plain_col,
  input  logic           ok_col,
  input  logic [128:1]   round_key,
  output logic [128:1]   plain_key,
  output logic           ok_key,
  output logic [3:0]     round_num,
  output logic           is_first,
  output logic           is_final,
  output logic [128:1]   cipher,
  output logic           done,
  output logic           busy
);

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q;
  logic [128:1]   plain_key_q;
  logic [128:1]   cipher_q;
  logic           ok_key_q;
  logic           done_q;
  logic           busy_q;
  logic [3:0]     round_num_q;
  logic [128:1]   sum;

  // Plain bitwise XOR; bit n of the state pairs with bit n of the key.
  assign sum = plain_col ^ round_key;

  // Control FSM and registered datapath; the pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      plain_key_q <= '0;
      cipher_q    <= '0;
      ok_key_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      round_num_q <= 4'd0;
    end else begin
      ok_key_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // ok_col is deliberately ignored here, even alongside start.
          if (start) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            round_num_q <= 4'd0;
          end
        end
        StRun: begin
          // start is ignored while a block is in flight.
          if (ok_col) begin
            if (round_num_q == LastRound) begin
              cipher_q    <= sum;
              done_q      <= 1'b1;
              round_num_q <= 4'd0;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end else begin
              plain_key_q <= sum;
              ok_key_q    <= 1'b1;
              round_num_q <= round_num_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign plain_key = plain_key_q;
  assign cipher    = cipher_q;
  assign ok_key    = ok_key_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign round_num = round_num_q;

  // Qualifiers for the plain_col arriving this cycle, decoded from the registered round index.
  assign is_first = (round_num_q == 4'd0);
  assign is_final = (round_num_q == LastRound);

endmodule

// File: tb/tb_addkey_round.sv
// Directed bench for addkey_round using the FIPS-197 AES-128 example block.
module tb_addkey_round;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [128:1]   plain_col;
  logic           ok_col;
  logic [128:1]   round_key;
  logic [128:1]   plain_key;
  logic           ok_key;
  logic [3:0]     round_num;
  logic           is_first;
  logic           is_final;
  logic [128:1]   cipher;
  logic           done;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  // Round inputs: plaintext, MixColumns outputs of rounds 1..9, ShiftRows output of round 10.
  logic [127:0] pc_tab [0:10];
  logic [127:0] key_tab [0:10];

  addkey_round #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .plain_col (plain_col),
    .ok_col    (ok_col),
    .round_key (round_key),
    .plain_key (plain_key),
    .ok_key    (ok_key),
    .round_num (round_num),
    .is_first  (is_first),
    .is_final  (is_final),
    .cipher    (cipher),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".plain_key"}, plain_key, 128'h0);
    check({tag, ".cipher"},    cipher,    128'h0);
    check({tag, ".ok_key"},    ok_key,    0);
    check({tag, ".done"},      done,      0);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".round_num"}, round_num, 0);
    check({tag, ".is_first"},  is_first,  1);
    check({tag, ".is_final"},  is_final,  0);
  endtask

  initial begin
    logic [127:0] last_pk;
    logic [127:0] exp_c;
    int           n_ok;

    pc_tab[0]  = 128'h00112233445566778899aabbccddeeff;
    pc_tab[1]  = 128'h5f72641557f5bc92f7be3b291db9f91a;
    pc_tab[2]  = 128'hff87968431d86a51645151fa773ad009;
    pc_tab[3]  = 128'h4c9c1e66f771f0762c3f868e534df256;
    pc_tab[4]  = 128'h6385b79ffc538df997be478e7547d691;
    pc_tab[5]  = 128'hf4bcd45432e554d075f1d6c51dd03b3c;
    pc_tab[6]  = 128'h9816ee7400f87f556b2c049c8e5ad036;
    pc_tab[7]  = 128'hc57e1c159a9bd286f05f4be098c63439;
    pc_tab[8]  = 128'hbaa03de7a1f9b56ed5512cba5f414d23;
    pc_tab[9]  = 128'he9f74eec023020f61bf2ccf2353c21c7;
    pc_tab[10] = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    key_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    key_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    key_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    key_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    key_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    key_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    key_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    key_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    key_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    key_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    key_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst_n     = 1'b0;
    start     = 1'b0;
    ok_col    = 1'b0;
    plain_col = pc_tab[0];
    round_key = key_tab[0];
    tick;
    tick;
    check_reset_state("reset");

    // ok_col alone in IDLE, then start together with ok_col.
    rst_n  = 1'b1;
    ok_col = 1'b1;
    tick;
    check("idle_okcol.ok_key", ok_key, 0);
    check("idle_okcol.busy", busy, 0);
    check("idle_okcol.round_num", round_num, 0);
    start = 1'b1;
    tick;
    start  = 1'b0;
    ok_col = 1'b0;
    check("start_okcol.ok_key", ok_key, 0);
    check("start_okcol.done", done, 0);
    check("start_okcol.busy", busy, 1);
    check("start_okcol.round_num", round_num, 0);
    check("start_okcol.is_first", is_first, 1);

    // Round 0 AddRoundKey of the FIPS-197 block.
    ok_col = 1'b1;
    tick;
    ok_col = 1'b0;
    check("r0.plain_key", plain_key, 128'h00102030405060708090a0b0c0d0e0f0);
    check("r0.ok_key", ok_key, 1);
    check("r0.round_num", round_num, 1);
    check("r0.is_first", is_first, 0);
    n_ok = 1;

    // Idle cycle in RUN with a stray start: everything holds, pulse drops.
    start = 1'b1;
    tick;
    start = 1'b0;
    check("hold.ok_key", ok_key, 0);
    check("hold.round_num", round_num, 1);
    check("hold.plain_key", plain_key, 128'h00102030405060708090a0b0c0d0e0f0);
    check("hold.busy", busy, 1);

    // Rounds 1..9, one idle cycle between each.
    for (int r = 1; r <= 9; r++) begin
      plain_col = pc_tab[r];
      round_key = key_tab[r];
      ok_col    = 1'b1;
      tick;
      ok_col = 1'b0;
      if (ok_key === 1'b1) n_ok++;
      check($sformatf("r%0d.plain_key", r), plain_key, pc_tab[r] ^ key_tab[r]);
      check($sformatf("r%0d.round_num", r), round_num, 128'(r + 1));
      check($sformatf("r%0d.done", r), done, 0);
      tick;
      check($sformatf("r%0d.ok_key_gap", r), ok_key, 0);
    end
    check("aes.ok_key_count", 128'(n_ok), 128'd10);
    check("r10.is_final", is_final, 1);
    check("r10.is_first", is_first, 0);
    last_pk = pc_tab[9] ^ key_tab[9];

    // Final round.
    plain_col = pc_tab[10];
    round_key = key_tab[10];
    ok_col    = 1'b1;
    tick;
    ok_col = 1'b0;
    check("final.cipher", cipher, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("final.done", done, 1);
    check("final.ok_key", ok_key, 0);
    check("final.plain_key", plain_key, last_pk);
    check("final.busy", busy, 0);
    check("final.round_num", round_num, 0);
    check("final.is_final", is_final, 0);
    tick;
    check("after.done", done, 0);
    check("after.cipher", cipher, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Abort mid-block with reset at round_num 5.
    start = 1'b1;
    tick;
    start  = 1'b0;
    ok_col = 1'b1;
    for (int r = 0; r < 5; r++) tick;
    check("abort.round_num", round_num, 5);
    rst_n = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check_reset_state("abort");
    rst_n = 1'b1;
    tick;
    tick;
    ok_col = 1'b0;
    check("abort.ignored_ok_key", ok_key, 0);
    check("abort.ignored_done", done, 0);
    check("abort.ignored_busy", busy, 0);
    check("abort.ignored_round", round_num, 0);

    // Eleven back-to-back ok_col pulses.
    start = 1'b1;
    tick;
    start  = 1'b0;
    ok_col = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      plain_col = {4{32'hA5A50000 + 32'(i)}};
      round_key = {4{32'h0F0F1234 ^ 32'(i << 8)}};
      exp_c     = {4{(32'hA5A50000 + 32'(i)) ^ (32'h0F0F1234 ^ 32'(i << 8))}};
      tick;
      check($sformatf("b2b%0d.ok_key", i), ok_key, (i <= 10) ? 128'd1 : 128'd0);
      check($sformatf("b2b%0d.done", i), done, (i == 11) ? 128'd1 : 128'd0);
      if (i <= 10) begin
        check($sformatf("b2b%0d.plain_key", i), plain_key, exp_c);
        check($sformatf("b2b%0d.round_num", i), round_num, 128'(i));
      end else begin
        check("b2b.cipher", cipher, exp_c);
        check("b2b.round_num", round_num, 0);
        check("b2b.busy", busy, 0);
      end
    end
    ok_col = 1'b0;
    tick;
    check("b2b.done_clear", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addkey_round.md
ADDKEY_ROUND -- requirements
Module: addkey_round

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of cipher rounds; the legal values are 10, 12 and 14.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin a new block.
REQ-005 SHALL have port plain_col, input, 128 bits [128:1]: state word from the column-mix stage.
REQ-006 SHALL have port ok_col, input, 1 bit: one-cycle pulse marking plain_col valid.
REQ-007 SHALL have port round_key, input, 128 bits [128:1]: round key for the current round_num, held stable by the key schedule.
REQ-008 SHALL have port plain_key, output, 128 bits [128:1]: registered AddRoundKey result, fed back to the byte-substitution stage.
REQ-009 SHALL have port ok_key, output, 1 bit: one-cycle pulse marking plain_key valid.
REQ-010 SHALL have port round_num, output, 4 bits: the current round index, 0..NR.
REQ-011 SHALL have port is_first, output, 1 bit: high when round_num==0.
REQ-012 SHALL have port is_final, output, 1 bit: high when round_num==NR.
REQ-013 SHALL have port cipher, output, 128 bits [128:1]: final ciphertext, held until the next done.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking cipher valid.
REQ-015 SHALL have port busy, output, 1 bit: high while a block is in progress.

Function
REQ-016 SHALL implement the two states IDLE and RUN.
REQ-017 SHALL, in IDLE with start=1, move to RUN, set busy=1 and round_num=0 on the same edge.
REQ-018 SHALL ignore ok_col in IDLE, including when ok_col and start are high in the same cycle.
REQ-019 SHALL ignore start in RUN.
REQ-020 SHALL, in RUN with ok_col=1 and round_num<NR, register plain_key <= plain_col XOR round_key, pulse ok_key high for exactly one cycle, and increment round_num.
REQ-021 SHALL, in RUN with ok_col=1 and round_num==NR, register cipher <= plain_col XOR round_key, pulse done for one cycle, keep ok_key=0 and plain_key unchanged, clear round_num to 0, clear busy, and return to IDLE.
REQ-022 SHALL have a latency of exactly one clock from ok_col to ok_key or done.
REQ-023 SHALL accept back-to-back ok_col pulses (one every cycle) without loss.
REQ-024 SHALL derive is_first and is_final combinationally from the registered round_num, so that they are valid in the same cycle as the plain_col they qualify.
REQ-025 SHALL perform the XOR bitwise over all 128 bits with no byte reordering.
REQ-026 SHALL, in RUN with ok_col=0, hold all registers.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, set: state=IDLE; plain_key=0; cipher=0; ok_key=0; done=0; busy=0; round_num=0 (hence is_first=1, is_final=0).
REQ-028 SHALL give reset priority over start and ok_col, including when reset occurs mid-block.
REQ-029 SHALL discard an aborted block entirely, producing no done for it.

Verification
V-1 Reset, then start, then ok_col with plain_col=00112233445566778899aabbccddeeff and round_key=000102030405060708090a0b0c0d0e0f -> next cycle: plain_key=00102030405060708090a0b0c0d0e0f0, ok_key=1, round_num=1, is_first=0.
V-2 Drive a full FIPS-197 AES-128 round sequence (plaintext and key from V-1, round_num 0..10) -> exactly 10 ok_key pulses, then done=1 with cipher=69c4e0d86a7b0430d8cdb78070b4c55a, busy=0, round_num=0.
V-3 With round_num==10: is_final=1 -> the ok_col cycle yields done=1 and ok_key=0; plain_key holds the round-9 value.
V-4 ok_col pulses in IDLE, and start+ok_col in the same cycle -> no ok_key, no done, round_num stays 0; busy=1 only after start.
V-5 rst_n=0 while round_num=5 -> next edge: all outputs at reset values; a later ok_col without start is ignored.
V-6 ok_col high for 11 consecutive cycles after start -> ok_key high for cycles 1..10, done high at cycle 11, no gaps.
